mc_control: RTL and testbench

- Multicycle control unit for the 32-bit datapath; sits directly upstream of the ALU.
- Decodes the instruction-register opcode/funct fields and sequences fetch/decode/execute/memory/writeback.
- Drives the ALU operation select (aluctr, encodings `ALU_ADD/`ALU_SUB/`ALU_AND/`ALU_OR from def.sv) and operand muxes.
- Consumes the ALU zero flag for branch resolution.

---
 rtl/mc_control.sv | 217 +++++++++++++++++++++
 tb/tb_mc_control.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// mc_control: multicycle control unit for the 32-bit datapath.
// Decodes op/funct from the instruction register and sequences
// fetch/decode/execute/memory/writeback, driving the ALU select and
// datapath mux/enable controls.
// Optional build macro: MC_CONTROL_ADDI_EN (adds the addi sequence;
// without it op 001000 decodes as illegal).
//
// state   | meaning
// --------+-----------------------------------------------------------
// FETCH   | read instruction at PC, load IR, PC <= PC + 4
// DECODE  | precompute branch target into ALUOut, dispatch on op
// MEMADR  | compute lw/sw effective address
// MEMRD   | read data memory at ALUOut
// MEMWB   | write loaded data to rt
// MEMWR   | write register B to data memory at ALUOut
// RTYPEEX | R-type ALU operation selected by funct
// RTYPEWB | write ALU result to rd
// BEQEX   | compare A and B, take branch when zero
// JEX     | load jump target into PC
// ADDIEX  | A + sign-extended immediate (MC_CONTROL_ADDI_EN only)
// ADDIWB  | write ALU result to rt (MC_CONTROL_ADDI_EN only)
// ILLEGAL | undecodable instruction, parked until reset

`ifndef ALU_ADD
`define ALU_ADD 2'b00
`endif
`ifndef ALU_SUB
`define ALU_SUB 2'b01
`endif
`ifndef ALU_AND
`define ALU_AND 2'b10
`endif
`ifndef ALU_OR
`define ALU_OR 2'b11
`endif

module mc_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [1:0] aluctr,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       illegal
);

  localparam int STATE_W = 4;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CONTROL_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_JEX     = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  state_t state, state_next;
  logic   illegal_q;

  // State register; reset pulls straight back to FETCH without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Sticky illegal flag, raised on the edge that enters ILLEGAL so it is visible in that state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       illegal_q <= 1'b0;
    else if (state_next == S_ILLEGAL) illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;

  // Next-state and Moore outputs; pcen in BEQEX and aluctr in RTYPEEX are the only input-dependent outputs.
  always_comb begin
    state_next = S_FETCH;
    aluctr     = `ALU_ADD;
    alusrca    = 1'b0;
    alusrcb    = 2'd0;
    pcsrc      = 2'd0;
    pcen       = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    case (state)
      S_FETCH: begin
        irwrite    = 1'b1;
        alusrcb    = 2'd1;
        pcen       = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'd3;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_J:         state_next = S_JEX;
`ifdef MC_CONTROL_ADDI_EN
          OP_ADDI:      state_next = S_ADDIEX;
`endif
          default:      state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'd2;
        state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord       = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        state_next = S_RTYPEWB;
        case (funct)
          FN_ADD:  aluctr = `ALU_ADD;
          FN_SUB:  aluctr = `ALU_SUB;
          FN_AND:  aluctr = `ALU_AND;
          FN_OR:   aluctr = `ALU_OR;
          default: state_next = S_ILLEGAL;
        endcase
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        aluctr     = `ALU_SUB;
        pcsrc      = 2'd1;
        pcen       = zero;
        state_next = S_FETCH;
      end
      S_JEX: begin
        pcsrc      = 2'd2;
        pcen       = 1'b1;
        state_next = S_FETCH;
      end
`ifdef MC_CONTROL_ADDI_EN
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'd2;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end
`endif
      S_ILLEGAL: state_next = S_ILLEGAL;
      default:   state_next = S_FETCH;
    endcase
    // Combinational gate so nothing but aluctr=ADD escapes while reset is held.
    if (reset) begin
      aluctr   = `ALU_ADD;
      alusrca  = 1'b0;
      alusrcb  = 2'd0;
      pcsrc    = 2'd0;
      pcen     = 1'b0;
      iord     = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed-vector bench for mc_control. Outputs are packed as
// {aluctr, alusrca, alusrcb, pcsrc, pcen, iord, memwrite, irwrite,
//  regdst, memtoreg, regwrite, illegal} and compared once per cycle
// against hand-written per-state constants.
module tb_mc_control;

  localparam logic [1:0] A_ADD = 2'b00;
  localparam logic [1:0] A_SUB = 2'b01;
  localparam logic [1:0] A_AND = 2'b10;
  localparam logic [1:0] A_OR  = 2'b11;

  localparam logic [14:0] O_RESET   = 15'd0;
  localparam logic [14:0] O_FETCH   = {2'b00, 1'b0, 2'd1, 2'd0, 1'b1, 7'b0010000};
  localparam logic [14:0] O_DECODE  = {2'b00, 1'b0, 2'd3, 2'd0, 1'b0, 7'b0000000};
  localparam logic [14:0] O_MEMADR  = {2'b00, 1'b1, 2'd2, 2'd0, 1'b0, 7'b0000000};
  localparam logic [14:0] O_MEMRD   = {8'b0, 7'b1000000};
  localparam logic [14:0] O_MEMWB   = {8'b0, 7'b0000110};
  localparam logic [14:0] O_MEMWR   = {8'b0, 7'b1100000};
  localparam logic [14:0] O_RTYPEWB = {8'b0, 7'b0001010};
  localparam logic [14:0] O_JEX     = {2'b00, 1'b0, 2'd0, 2'd2, 1'b1, 7'b0000000};
  localparam logic [14:0] O_ILLEGAL = {8'b0, 7'b0000001};
  localparam logic [14:0] O_ADDIEX  = {2'b00, 1'b1, 2'd2, 2'd0, 1'b0, 7'b0000000};
  localparam logic [14:0] O_ADDIWB  = {8'b0, 7'b0000010};

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic [1:0] aluctr, alusrcb, pcsrc;
  logic       alusrca, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, illegal;

  int vectors     = 0;
  int miscompares = 0;

  mc_control dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .aluctr(aluctr), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] outs();
    return {aluctr, alusrca, alusrcb, pcsrc, pcen, iord, memwrite, irwrite,
            regdst, memtoreg, regwrite, illegal};
  endfunction

  task automatic test_reset();
    reset = 1'b1; op = 6'b100011; funct = 6'd0; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (outs() !== O_RESET) begin
        miscompares++;
        $display("FAIL reset_hold cyc%0d: got %b expected %b", i, outs(), O_RESET);
      end
    end
    reset = 1'b0; #1;
    vectors++;
    if (outs() !== O_FETCH) begin
      miscompares++;
      $display("FAIL reset_release_fetch: got %b expected %b", outs(), O_FETCH);
    end
    @(negedge clk);
    vectors++;
    if (outs() !== O_DECODE) begin
      miscompares++;
      $display("FAIL reset_release_decode: got %b expected %b", outs(), O_DECODE);
    end
    reset = 1'b1; #1;
    vectors++;
    if (outs() !== O_RESET) begin
      miscompares++;
      $display("FAIL reset_midinstr: got %b expected %b", outs(), O_RESET);
    end
    reset = 1'b0; #1;
    vectors++;
    if (outs() !== O_FETCH) begin
      miscompares++;
      $display("FAIL reset_midinstr_fetch: got %b expected %b", outs(), O_FETCH);
    end
  endtask

  task automatic test_lw();
    logic [14:0] exp [6];
    exp = '{O_FETCH, O_DECODE, O_MEMADR, O_MEMRD, O_MEMWB, O_FETCH};
    op = 6'b100011; #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (outs() !== exp[i]) begin
        miscompares++;
        $display("FAIL lw cyc%0d: got %b expected %b", i, outs(), exp[i]);
      end
    end
  endtask

  task automatic test_sw();
    logic [14:0] exp [5];
    exp = '{O_FETCH, O_DECODE, O_MEMADR, O_MEMWR, O_FETCH};
    op = 6'b101011; #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (outs() !== exp[i]) begin
        miscompares++;
        $display("FAIL sw cyc%0d: got %b expected %b", i, outs(), exp[i]);
      end
    end
  endtask

  task automatic test_rtype();
    logic [5:0]  fn  [4];
    logic [1:0]  alu [4];
    logic [14:0] exp [5];
    fn  = '{6'b100010, 6'b100100, 6'b100101, 6'b100000};
    alu = '{A_SUB, A_AND, A_OR, A_ADD};
    for (int k = 0; k < 4; k++) begin
      exp = '{O_FETCH, O_DECODE, {alu[k], 1'b1, 2'd0, 2'd0, 1'b0, 7'b0}, O_RTYPEWB, O_FETCH};
      op = 6'b000000; funct = fn[k]; #1;
      for (int i = 0; i < 5; i++) begin
        if (i > 0) @(negedge clk);
        vectors++;
        if (outs() !== exp[i]) begin
          miscompares++;
          $display("FAIL rtype funct%b cyc%0d: got %b expected %b", fn[k], i, outs(), exp[i]);
        end
      end
    end
  endtask

  task automatic test_beq();
    logic [14:0] exp [4];
    for (int z = 1; z >= 0; z--) begin
      exp = '{O_FETCH, O_DECODE, {A_SUB, 1'b1, 2'd0, 2'd1, z[0], 7'b0}, O_FETCH};
      op = 6'b000100; zero = z[0]; #1;
      for (int i = 0; i < 4; i++) begin
        if (i > 0) @(negedge clk);
        vectors++;
        if (outs() !== exp[i]) begin
          miscompares++;
          $display("FAIL beq zero%0d cyc%0d: got %b expected %b", z, i, outs(), exp[i]);
        end
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jump();
    logic [14:0] exp [4];
    exp = '{O_FETCH, O_DECODE, O_JEX, O_FETCH};
    op = 6'b000010; #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (outs() !== exp[i]) begin
        miscompares++;
        $display("FAIL jump cyc%0d: got %b expected %b", i, outs(), exp[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [14:0] exp [14];
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin
        op = 6'b111111; funct = 6'b100000;
        exp[0] = O_FETCH; exp[1] = O_DECODE;
        for (int i = 2; i < 14; i++) exp[i] = O_ILLEGAL;
      end else begin
        op = 6'b000000; funct = 6'b000111;
        exp[0] = O_FETCH; exp[1] = O_DECODE;
        exp[2] = {A_ADD, 1'b1, 2'd0, 2'd0, 1'b0, 7'b0};
        for (int i = 3; i < 14; i++) exp[i] = O_ILLEGAL;
      end
      #1;
      for (int i = 0; i < 14; i++) begin
        if (i > 0) @(negedge clk);
        vectors++;
        if (outs() !== exp[i]) begin
          miscompares++;
          $display("FAIL illegal case%0d cyc%0d: got %b expected %b", c, i, outs(), exp[i]);
        end
      end
      reset = 1'b1; #1;
      vectors++;
      if (outs() !== O_RESET) begin
        miscompares++;
        $display("FAIL illegal_clear case%0d: got %b expected %b", c, outs(), O_RESET);
      end
      reset = 1'b0; #1;
      vectors++;
      if (outs() !== O_FETCH) begin
        miscompares++;
        $display("FAIL illegal_restart case%0d: got %b expected %b", c, outs(), O_FETCH);
      end
    end
    funct = 6'd0;
  endtask

  task automatic test_addi();
    logic [14:0] exp [5];
`ifdef MC_CONTROL_ADDI_EN
    exp = '{O_FETCH, O_DECODE, O_ADDIEX, O_ADDIWB, O_FETCH};
`else
    exp = '{O_FETCH, O_DECODE, O_ILLEGAL, O_ILLEGAL, O_ILLEGAL};
`endif
    op = 6'b001000; #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (outs() !== exp[i]) begin
        miscompares++;
        $display("FAIL addi cyc%0d: got %b expected %b", i, outs(), exp[i]);
      end
    end
    reset = 1'b1; #1;
    reset = 1'b0; #1;
    vectors++;
    if (outs() !== O_FETCH) begin
      miscompares++;
      $display("FAIL addi_restart: got %b expected %b", outs(), O_FETCH);
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] exp [8];
    exp = '{O_FETCH, O_DECODE, O_JEX, O_FETCH, O_DECODE, O_MEMADR, O_MEMWR, O_FETCH};
    op = 6'b000010; #1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 3) begin op = 6'b101011; #1; end
      vectors++;
      if (outs() !== exp[i]) begin
        miscompares++;
        $display("FAIL back_to_back cyc%0d: got %b expected %b", i, outs(), exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_beq();
    test_jump();
    test_back_to_back();
    test_illegal();
    test_addi();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
